// File: rtl/fastram_bus_ctrl.sv
// rtl/fastram_bus_ctrl.sv - Zorro II fast-RAM select to SRAM strobes with timed DTACK
`timescale 1ns/1ps
//
// Converts the autoconfig fast-RAM hit (ram_sel) plus the 68000 bus strobes
// into SRAM chip/output/write enables and a DTACK with programmable wait states.
//
// Parameters
//   WAIT_STATES  CLK cycles between CE assertion and DTACK assertion, minus one (0..7)
//   RECOVERY     idle CLK cycles forced after each access (1..3)
//
// Ports
//   CLK       in   68000 CPU clock, sampled on rising edges
//   _RST      in   asynchronous active-low reset
//   _AS       in   address strobe, active-low
//   _UDS      in   upper data strobe, active-low
//   _LDS      in   lower data strobe, active-low
//   RW        in   1 = read, 0 = write
//   ram_sel   in   fast-RAM range hit, positive logic
//   _RAM_CE   out  SRAM chip enable, active-low
//   _RAM_OE   out  SRAM output enable, active-low
//   _RAM_WEU  out  SRAM write enable D15..8, active-low
//   _RAM_WEL  out  SRAM write enable D7..0, active-low
//   DTACK     out  data acknowledge, positive logic
//   busy      out  high whenever the controller is not idle

module fastram_bus_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int RECOVERY    = 1
) (
  input  logic CLK,
  input  logic _RST,
  input  logic _AS,
  input  logic _UDS,
  input  logic _LDS,
  input  logic RW,
  input  logic ram_sel,
  output logic _RAM_CE,
  output logic _RAM_OE,
  output logic _RAM_WEU,
  output logic _RAM_WEL,
  output logic DTACK,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    ACK     = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [2:0] WS_LOAD  = 3'(WAIT_STATES);
  localparam logic [2:0] REC_LOAD = 3'(RECOVERY - 1);

  state_t     state, state_nxt;
  logic [2:0] count, count_nxt;
  logic       rw_lat, rw_lat_nxt;
  logic       start;
  logic       in_cycle;

  // A read or write with neither data strobe low never starts an access.
  assign start = !_AS && ram_sel && (!_UDS || !_LDS);

  // State register
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state  <= IDLE;
      count  <= 3'd0;
      rw_lat <= 1'b1;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      rw_lat <= rw_lat_nxt;
    end
  end

  // Next-state logic. The counter only decrements when non-zero, so it
  // saturates at zero instead of wrapping.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    rw_lat_nxt = rw_lat;
    case (state)
      IDLE: begin
        if (start) begin
          rw_lat_nxt = RW;
          count_nxt  = WS_LOAD;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        // Aborted cycle: _AS negated before DTACK, release without acknowledging.
        if (_AS) begin
          count_nxt = REC_LOAD;
          state_nxt = RECOVER;
        end else if (count == 3'd0) begin
          state_nxt = ACK;
        end else begin
          count_nxt = count - 3'd1;
        end
      end
      ACK: begin
        if (_AS) begin
          count_nxt = REC_LOAD;
          state_nxt = RECOVER;
        end
      end
      RECOVER: begin
        if (count == 3'd0) begin
          state_nxt = IDLE;
        end else begin
          count_nxt = count - 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 3'd0;
      end
    endcase
  end

  // Output decode. Write enables also gate on the live data strobes so WE
  // releases in the same half-cycle the CPU negates UDS/LDS.
  always_comb begin
    in_cycle  = (state == ACCESS) || (state == ACK);
    _RAM_CE   = !in_cycle;
    _RAM_OE   = !(in_cycle && rw_lat);
    _RAM_WEU  = !(in_cycle && !rw_lat && !_UDS);
    _RAM_WEL  = !(in_cycle && !rw_lat && !_LDS);
    DTACK     = (state == ACK);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_fastram_bus_ctrl.sv
// tb/tb_fastram_bus_ctrl.sv - self-checking bench for fastram_bus_ctrl
`timescale 1ns/1ps

module tb_fastram_bus_ctrl;

  localparam int WS_A  = 1;
  localparam int REC_A = 2;
  localparam int WS_B  = 3;
  localparam int REC_B = 1;

  logic CLK = 1'b0;
  logic _RST, _AS, _UDS, _LDS, RW, ram_sel;
  logic ce_a, oe_a, weu_a, wel_a, dtack_a, busy_a;
  logic ce_b, oe_b, weu_b, wel_b, dtack_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];

  always #5 CLK = ~CLK;

  fastram_bus_ctrl #(.WAIT_STATES(WS_A), .RECOVERY(REC_A)) dut_a (
    .CLK(CLK), ._RST(_RST), ._AS(_AS), ._UDS(_UDS), ._LDS(_LDS), .RW(RW), .ram_sel(ram_sel),
    ._RAM_CE(ce_a), ._RAM_OE(oe_a), ._RAM_WEU(weu_a), ._RAM_WEL(wel_a), .DTACK(dtack_a), .busy(busy_a)
  );

  fastram_bus_ctrl #(.WAIT_STATES(WS_B), .RECOVERY(REC_B)) dut_b (
    .CLK(CLK), ._RST(_RST), ._AS(_AS), ._UDS(_UDS), ._LDS(_LDS), .RW(RW), .ram_sel(ram_sel),
    ._RAM_CE(ce_b), ._RAM_OE(oe_b), ._RAM_WEU(weu_b), ._RAM_WEL(wel_b), .DTACK(dtack_b), .busy(busy_b)
  );

  task automatic bus_idle();
    _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1; RW = 1'b1; ram_sel = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while ((busy_a || busy_b) && i < 20) begin
      @(posedge CLK); #1;
      i++;
    end
    n_cmp++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle timeout: busy_a=%b busy_b=%b want 0/0", tag, busy_a, busy_b);
    end
  endtask

  // Starts an access on dut_a and leaves the bus in ACK with _AS still low.
  task automatic access_a(input logic rw, input logic uds, input logic lds, input string tag);
    int n, exp_lat;
    logic seen;
    @(negedge CLK);
    _AS = 1'b0; RW = rw; _UDS = uds; _LDS = lds; ram_sel = 1'b1;
    exp_q.push_back(WS_A + 1);
    @(posedge CLK); #1;
    n_cmp++; if (ce_a !== 1'b0) begin n_bad++; $display("FAIL %s ce: got %b want 0", tag, ce_a); end
    n_cmp++; if (oe_a !== !rw) begin n_bad++; $display("FAIL %s oe: got %b want %b", tag, oe_a, !rw); end
    n_cmp++; if (weu_a !== !(!rw && !uds)) begin n_bad++; $display("FAIL %s weu: got %b want %b", tag, weu_a, !(!rw && !uds)); end
    n_cmp++; if (wel_a !== !(!rw && !lds)) begin n_bad++; $display("FAIL %s wel: got %b want %b", tag, wel_a, !(!rw && !lds)); end
    n_cmp++; if (busy_a !== 1'b1 || dtack_a !== 1'b0) begin n_bad++; $display("FAIL %s busy/dtack: got %b/%b want 1/0", tag, busy_a, dtack_a); end
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge CLK); #1;
      n++;
      if (dtack_a === 1'b1) seen = 1'b1;
    end
    exp_lat = exp_q.pop_front();
    n_cmp++;
    if (!seen || n != exp_lat) begin n_bad++; $display("FAIL %s dtack latency: got %0d (seen=%b) want %0d", tag, n, seen, exp_lat); end
    n_cmp++; if (ce_a !== 1'b0) begin n_bad++; $display("FAIL %s ce in ack: got %b want 0", tag, ce_a); end
  endtask

  // Negates _AS and the data strobes; dut_a must drop everything on the next edge.
  task automatic end_cycle_a(input string tag);
    @(negedge CLK);
    _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1; ram_sel = 1'b0;
    @(posedge CLK); #1;
    n_cmp++;
    if ({ce_a, oe_a, weu_a, wel_a, dtack_a, busy_a} !== 6'b111101) begin
      n_bad++;
      $display("FAIL %s release: got ce/oe/weu/wel/dtack/busy=%b want 111101", tag, {ce_a, oe_a, weu_a, wel_a, dtack_a, busy_a});
    end
    wait_idle(tag);
  endtask

  task automatic test_reset();
    _RST = 1'b0;
    bus_idle();
    #12;
    n_cmp++;
    if ({ce_a, oe_a, weu_a, wel_a, dtack_a, busy_a} !== 6'b111100) begin
      n_bad++; $display("FAIL reset_a: got %b want 111100", {ce_a, oe_a, weu_a, wel_a, dtack_a, busy_a});
    end
    n_cmp++;
    if ({ce_b, oe_b, weu_b, wel_b, dtack_b, busy_b} !== 6'b111100) begin
      n_bad++; $display("FAIL reset_b: got %b want 111100", {ce_b, oe_b, weu_b, wel_b, dtack_b, busy_b});
    end
    @(negedge CLK);
    _RST = 1'b1;
  endtask

  task automatic test_read();
    access_a(1'b1, 1'b0, 1'b0, "read_word");
    end_cycle_a("read_word");
  endtask

  task automatic test_byte_writes();
    access_a(1'b0, 1'b0, 1'b1, "write_upper");
    @(negedge CLK);
    _UDS = 1'b1;
    #1;
    n_cmp++; if (weu_a !== 1'b1) begin n_bad++; $display("FAIL write_upper weu follows uds: got %b want 1", weu_a); end
    n_cmp++; if (ce_a !== 1'b0 || dtack_a !== 1'b1) begin n_bad++; $display("FAIL write_upper still ack: got ce=%b dtack=%b want 0/1", ce_a, dtack_a); end
    end_cycle_a("write_upper");
    access_a(1'b0, 1'b1, 1'b0, "write_lower");
    end_cycle_a("write_lower");
    access_a(1'b0, 1'b0, 1'b0, "write_word");
    end_cycle_a("write_word");
  endtask

  task automatic test_no_start();
    @(negedge CLK);
    _AS = 1'b0; _UDS = 1'b0; _LDS = 1'b0; RW = 1'b1; ram_sel = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      n_cmp++;
      if (ce_a !== 1'b1 || dtack_a !== 1'b0 || busy_a !== 1'b0) begin
        n_bad++; $display("FAIL no_select: got ce/dtack/busy=%b%b%b want 100", ce_a, dtack_a, busy_a);
      end
    end
    @(negedge CLK);
    ram_sel = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      n_cmp++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
        n_bad++; $display("FAIL no_ds: got busy_a=%b busy_b=%b want 0/0", busy_a, busy_b);
      end
    end
    @(negedge CLK);
    bus_idle();
    wait_idle("no_start");
  endtask

  task automatic test_abort();
    logic dt_seen;
    dt_seen = 1'b0;
    @(negedge CLK);
    _AS = 1'b0; _UDS = 1'b0; _LDS = 1'b0; RW = 1'b1; ram_sel = 1'b1;
    @(posedge CLK); #1;
    dt_seen |= dtack_b;
    n_cmp++; if (ce_b !== 1'b0 || busy_b !== 1'b1) begin n_bad++; $display("FAIL abort start: got ce=%b busy=%b want 0/1", ce_b, busy_b); end
    @(posedge CLK); #1;
    dt_seen |= dtack_b;
    @(negedge CLK);
    _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1; ram_sel = 1'b0;
    @(posedge CLK); #1;
    dt_seen |= dtack_b;
    n_cmp++; if (ce_b !== 1'b1 || oe_b !== 1'b1 || busy_b !== 1'b1) begin n_bad++; $display("FAIL abort release: got ce=%b oe=%b busy=%b want 1/1/1", ce_b, oe_b, busy_b); end
    repeat (4) begin
      @(posedge CLK); #1;
      dt_seen |= dtack_b;
    end
    n_cmp++; if (dt_seen !== 1'b0) begin n_bad++; $display("FAIL abort dtack: got seen=%b want 0", dt_seen); end
    wait_idle("abort");
  endtask

  task automatic test_back_to_back();
    int k, n, exp_lat;
    logic seen;
    access_a(1'b1, 1'b0, 1'b0, "b2b_first");
    @(negedge CLK);
    _AS = 1'b1;
    @(posedge CLK); #1;
    n_cmp++; if (ce_a !== 1'b1 || busy_a !== 1'b1) begin n_bad++; $display("FAIL b2b recover: got ce=%b busy=%b want 1/1", ce_a, busy_a); end
    @(negedge CLK);
    _AS = 1'b0;
    exp_q.push_back(WS_A + 1);
    k = 0;
    while (ce_a !== 1'b0 && k < 10) begin
      @(posedge CLK); #1;
      k++;
    end
    n_cmp++;
    if (k != REC_A + 1) begin n_bad++; $display("FAIL b2b second ce edge: got %0d want %0d", k, REC_A + 1); end
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge CLK); #1;
      n++;
      if (dtack_a === 1'b1) seen = 1'b1;
    end
    exp_lat = exp_q.pop_front();
    n_cmp++;
    if (!seen || n != exp_lat) begin n_bad++; $display("FAIL b2b second dtack: got %0d (seen=%b) want %0d", n, seen, exp_lat); end
    end_cycle_a("b2b_second");
  endtask

  task automatic test_reset_mid();
    access_a(1'b0, 1'b0, 1'b0, "rst_mid");
    @(negedge CLK);
    #2;
    _RST = 1'b0;
    #1;
    n_cmp++;
    if ({ce_a, oe_a, weu_a, wel_a, dtack_a, busy_a} !== 6'b111100) begin
      n_bad++; $display("FAIL rst_mid outputs: got %b want 111100", {ce_a, oe_a, weu_a, wel_a, dtack_a, busy_a});
    end
    @(negedge CLK);
    bus_idle();
    _RST = 1'b1;
    wait_idle("rst_mid");
    access_a(1'b1, 1'b0, 1'b0, "after_rst");
    end_cycle_a("after_rst");
  endtask

  initial begin
    test_reset();
    test_read();
    test_byte_writes();
    test_no_start();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
